// File: rtl/audio_i2s_rx_pkg.sv
// Shared constants, FSM encoding and helpers for the I2S receiver.
package audio_i2s_rx_pkg;

   localparam int unsigned DATA_W_DEF      = 16;
   localparam int unsigned SLOT_W_DEF      = 32;
   localparam int unsigned SYNC_STAGES_DEF = 2;

   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2,
      ST_PAD   = 2'd3
   } state_t;

   // True when the latched slot channel is the one selected for output.
   function automatic logic ch_match(input logic chan, input logic sel);
      return (sel == CH_RIGHT) ? (chan == CH_RIGHT) : (chan == CH_LEFT);
   endfunction

endpackage

// File: rtl/audio_i2s_rx_sync_edge.sv
// Multi-stage input synchroniser with optional rising-edge detect.
module audio_i2s_rx_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter bit          EDGE_EN     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic q,
   output logic rise_c
);

   logic [SYNC_STAGES-1:0] sync;

   // Shift the asynchronous pin through the synchroniser chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '0;
      end else begin
         sync <= SYNC_STAGES'({sync, din});
      end
   end

   assign q = sync[SYNC_STAGES-1];

   if (EDGE_EN) begin : g_edge
      logic prev;

      // Remember the previous synchronised level for edge detection.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            prev <= 1'b0;
         end else begin
            prev <= q;
         end
      end

      assign rise_c = q & ~prev;
   end else begin : g_no_edge
      assign rise_c = 1'b0;
   end

endmodule

// File: rtl/audio_i2s_rx.sv
// I2S receiver: oversamples bclk/lrclk/sdata and emits one sample per selected slot.
module audio_i2s_rx
   import audio_i2s_rx_pkg::*;
#(
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned SLOT_W      = SLOT_W_DEF,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i2s_bclk,
   input  logic                     i2s_lrclk,
   input  logic                     i2s_sdata,
   input  logic                     ch_sel,
   output logic signed [DATA_W-1:0] o_data,
   output logic                     val_out,
   output logic                     frame_err
);

   localparam int unsigned K_W = $clog2(SLOT_W + 1);
   localparam logic [K_W-1:0] LAST_K  = K_W'(DATA_W - 1);
   localparam logic [K_W-1:0] PAD_MAX = K_W'(SLOT_W - 1);

   logic              bit_en;
   logic              lrclk_s;
   logic              sdata_s;
   logic              unused_bclk_s;
   logic              unused_rise_lr;
   logic              unused_rise_sd;

   state_t            state;
   state_t            next_state;

   logic              lrclk_prev;
   logic              prev_vld;
   logic              done_bnd;
   logic              chan_q;
   logic              sel_q;
   logic [DATA_W-1:0] sr;
   logic [K_W-1:0]    k;

   logic              boundary_c;
   logic              shift_c;
   logic              k_inc_c;
   logic              k_clr_c;
   logic              latch_c;
   logic              err_c;
   logic              emit_c;

   audio_i2s_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_bclk (
      .clk    (clk),
      .rst    (rst),
      .din    (i2s_bclk),
      .q      (unused_bclk_s),
      .rise_c (bit_en)
   );

   audio_i2s_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_lrclk (
      .clk    (clk),
      .rst    (rst),
      .din    (i2s_lrclk),
      .q      (lrclk_s),
      .rise_c (unused_rise_lr)
   );

   audio_i2s_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_sdata (
      .clk    (clk),
      .rst    (rst),
      .din    (i2s_sdata),
      .q      (sdata_s),
      .rise_c (unused_rise_sd)
   );

   // A slot boundary needs a valid previous lrclk, so a partial first slot is never framed.
   assign boundary_c = bit_en & prev_vld & (lrclk_s != lrclk_prev);

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // FSM next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (boundary_c) next_state = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (bit_en && (k == LAST_K)) next_state = ST_DONE;
         end
         ST_DONE: begin
            next_state = done_bnd ? ST_SHIFT : ST_PAD;
         end
         ST_PAD: begin
            if (boundary_c) begin
               next_state = ST_SHIFT;
            end else if (bit_en && (k >= PAD_MAX)) begin
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // FSM control outputs driving the datapath.
   always_comb begin
      shift_c = 1'b0;
      k_inc_c = 1'b0;
      k_clr_c = 1'b0;
      latch_c = 1'b0;
      err_c   = 1'b0;
      emit_c  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (boundary_c) begin
               latch_c = 1'b1;
               k_clr_c = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (bit_en) begin
               if (k == LAST_K) begin
                  // Completing bit; may itself sit on the next boundary edge.
                  shift_c = 1'b1;
                  if (boundary_c) k_clr_c = 1'b1;
                  else            k_inc_c = 1'b1;
               end else if (boundary_c) begin
                  // Slot too short: drop the word and restart on this boundary.
                  err_c   = 1'b1;
                  latch_c = 1'b1;
                  k_clr_c = 1'b1;
               end else begin
                  shift_c = 1'b1;
                  k_inc_c = 1'b1;
               end
            end
         end
         ST_DONE: begin
            emit_c  = ch_match(chan_q, sel_q);
            latch_c = done_bnd;
         end
         ST_PAD: begin
            if (boundary_c) begin
               latch_c = 1'b1;
               k_clr_c = 1'b1;
            end else if (bit_en) begin
               if (k >= PAD_MAX) err_c   = 1'b1;
               else              k_inc_c = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Track lrclk per bit edge and whether the completing edge was a boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lrclk_prev <= CH_LEFT;
         prev_vld   <= 1'b0;
         done_bnd   <= 1'b0;
      end else if (bit_en) begin
         lrclk_prev <= lrclk_s;
         prev_vld   <= 1'b1;
         done_bnd   <= boundary_c;
      end
   end

   // Slot channel / selection latch, shift register and bit counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chan_q <= CH_LEFT;
         sel_q  <= CH_LEFT;
         sr     <= '0;
         k      <= '0;
      end else begin
         if (latch_c) begin
            // In DONE the boundary edge is one cycle old, so lrclk_prev holds the new channel.
            chan_q <= (state == ST_DONE) ? lrclk_prev : lrclk_s;
            sel_q  <= ch_sel;
         end
         if (shift_c) sr <= DATA_W'({sr, sdata_s});
         if (k_clr_c) begin
            k <= '0;
         end else if (k_inc_c) begin
            k <= k + K_W'(1);
         end
      end
   end

   // Registered outputs: sample, strobe and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_data    <= '0;
         val_out   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         val_out <= 1'b0;
         if (emit_c) begin
            o_data  <= $signed(sr);
            val_out <= 1'b1;
         end
         if (err_c) frame_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_audio_i2s_rx.sv
// Directed self-checking bench for audio_i2s_rx (32-bit and 16-bit slot instances).
module tb_audio_i2s_rx;
   import audio_i2s_rx_pkg::*;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned LAT    = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        bclk;
   logic        lrclk;
   logic        sdata;
   logic        ch_sel;
   logic [15:0] o_data;
   logic        val_out;
   logic        frame_err;
   logic [15:0] o_data16;
   logic        val16;
   logic        err16;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          t_apply  = 0;
   int          npulse   = 0;
   int          npulse16 = 0;
   logic [15:0] last_data = '0;
   logic [15:0] last16    = '0;
   logic [15:0] prev_odata = '0;
   logic        lat_en = 1'b0;
   logic        carry  = 1'b0;

   audio_i2s_rx #(.DATA_W(16), .SLOT_W(32), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .i2s_bclk  (bclk),
      .i2s_lrclk (lrclk),
      .i2s_sdata (sdata),
      .ch_sel    (ch_sel),
      .o_data    (o_data),
      .val_out   (val_out),
      .frame_err (frame_err)
   );

   audio_i2s_rx #(.DATA_W(16), .SLOT_W(16), .SYNC_STAGES(2)) dut16 (
      .clk       (clk),
      .rst       (rst),
      .i2s_bclk  (bclk),
      .i2s_lrclk (lrclk),
      .i2s_sdata (sdata),
      .ch_sel    (ch_sel),
      .o_data    (o_data16),
      .val_out   (val16),
      .frame_err (err16)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Pulse monitor: counts strobes, captures data, checks latency and hold.
   always @(negedge clk) begin
      if (val_out === 1'b1) begin
         npulse++;
         last_data = o_data;
         if (lat_en) check("latency", 32'(cyc - t_apply), 32'(LAT));
      end else if (rst === 1'b0 && o_data !== prev_odata) begin
         check("odata_hold", 32'(o_data), 32'(prev_odata));
      end
      prev_odata = o_data;
      if (val16 === 1'b1) begin
         npulse16++;
         last16 = o_data16;
      end
   end

   // One I2S slot, one bit delay after lrclk; bclk = clk/8 with data changing on falling bclk.
   task automatic send_slot(input logic lr, input logic [31:0] word, input int nbits,
                            input int tog_at, input int rst_at);
      for (int i = 0; i < nbits; i++) begin
         bclk  = 1'b0;
         lrclk = lr;
         sdata = (i == 0) ? carry : word[nbits - i];
         if (i == tog_at) ch_sel = ~ch_sel;
         if (i == rst_at) begin
            rst = 1'b1;
            #1;
            check("rst_odata", 32'(o_data), 32'h0);
            check("rst_val", 32'(val_out), 32'h0);
            check("rst_err", 32'(frame_err), 32'h0);
            repeat (3) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
         end else begin
            repeat (4) @(negedge clk);
         end
         bclk = 1'b1;
         if (i == DATA_W) t_apply = cyc;
         repeat (4) @(negedge clk);
      end
      carry = word[0];
   endtask

   task automatic send_frame(input logic [31:0] left, input logic [31:0] right, input int nbits);
      send_slot(CH_LEFT, left, nbits, -1, -1);
      send_slot(CH_RIGHT, right, nbits, -1, -1);
   endtask

   initial begin
      rst    = 1'b1;
      bclk   = 1'b0;
      lrclk  = 1'b0;
      sdata  = 1'b0;
      ch_sel = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_odata", 32'(o_data), 32'h0);
      check("reset_val", 32'(val_out), 32'h0);
      check("reset_err", 32'(frame_err), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Left channel, 32-bit slots
      lat_en = 1'b1;
      send_slot(CH_RIGHT, 32'h0, 32, -1, -1);
      npulse = 0;
      repeat (4) send_frame(32'h7FFF_0000, 32'h8001_0000, 32);
      check("t1_pulses", 32'(npulse), 32'd4);
      check("t1_data", 32'(last_data), 32'h7FFF);
      check("t1_err", 32'(frame_err), 32'h0);

      // Right channel, then a mid-slot ch_sel change
      ch_sel = 1'b1;
      npulse = 0;
      repeat (4) send_frame(32'h7FFF_0000, 32'h8001_0000, 32);
      check("t2_pulses", 32'(npulse), 32'd4);
      check("t2_data", 32'(last_data), 32'h8001);
      npulse = 0;
      send_slot(CH_LEFT, 32'h1111_0000, 32, 8, -1);
      send_slot(CH_RIGHT, 32'h2222_0000, 32, -1, -1);
      check("t2_toggle_none", 32'(npulse), 32'd0);
      send_frame(32'h3333_0000, 32'h4444_0000, 32);
      check("t2_toggle_pulses", 32'(npulse), 32'd1);
      check("t2_toggle_data", 32'(last_data), 32'h3333);

      // 24-bit words truncated to 16
      npulse = 0;
      repeat (2) send_frame(32'h1234_5600, 32'hABCD_EF00, 32);
      check("t3_pulses", 32'(npulse), 32'd2);
      check("t3_data", 32'(last_data), 32'h1234);
      check("t3_err", 32'(frame_err), 32'h0);

      // 16-bit slots, LSB on the boundary edge
      lat_en = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      carry = 1'b0;
      send_slot(CH_RIGHT, 32'h0, 16, -1, -1);
      npulse   = 0;
      npulse16 = 0;
      repeat (3) send_frame(32'h0000_A5C3, 32'h0000_5A3C, 16);
      check("t4_pulses16", 32'(npulse16), 32'd3);
      check("t4_data16", 32'(last16), 32'hA5C3);
      check("t4_err16", 32'(err16), 32'h0);
      check("t4_pulses32", 32'(npulse), 32'd3);
      check("t4_data32", 32'(last_data), 32'hA5C3);
      check("t4_err32", 32'(frame_err), 32'h0);

      // Short 12-bit slot raises the sticky error
      npulse = 0;
      send_slot(CH_LEFT, 32'h0000_0ABC, 12, -1, -1);
      send_slot(CH_RIGHT, 32'h0, 32, -1, -1);
      check("t5_err", 32'(frame_err), 32'h1);
      check("t5_no_pulse", 32'(npulse), 32'd0);
      send_frame(32'h0F0F_0000, 32'h0, 32);
      check("t5_pulses", 32'(npulse), 32'd1);
      check("t5_data", 32'(last_data), 32'h0F0F);
      check("t5_err_sticky", 32'(frame_err), 32'h1);

      // Reset in the middle of a selected slot
      npulse = 0;
      send_slot(CH_LEFT, 32'h7777_0000, 32, -1, 10);
      send_slot(CH_RIGHT, 32'h0, 32, -1, -1);
      check("t6_no_pulse", 32'(npulse), 32'd0);
      check("t6_odata_zero", 32'(o_data), 32'h0);
      send_frame(32'h5555_0000, 32'h0, 32);
      check("t6_pulses", 32'(npulse), 32'd1);
      check("t6_data", 32'(last_data), 32'h5555);
      check("t6_err", 32'(frame_err), 32'h0);

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
